qbus_slave_ctl: RTL and testbench

- Synthesizable QBUS slave sequencer for the DE0 build of the 1801VM3 replica. It replaces behavioural bus-reply logic with a clocked state machine.
- Latches the address on SYNC, decodes the RAM window and register window, and issues one-cycle read/write strobes to a backend.
- Drives inverted AD and RPLY, and answers IAKO with vectors from a fixed-priority interrupt arbiter.
- Sits between the vm3 pins and the board RAM/peripheral registers. All bus inputs are synchronous to clk, so no synchronizers are used.

---
 rtl/qbus_pkg.sv | 32 +++
 rtl/qbus_irq_arb.sv | 28 ++
 rtl/qbus_slave_ctl.sv | 201 ++++++++++++++++++++
 tb/tb_qbus_slave_ctl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_pkg.sv
// rtl/qbus_pkg.sv - shared state codes and address map for the QBUS slave sequencer
package qbus_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_ADDR     = 4'd1;
    localparam state_t S_RD_WAIT  = 4'd2;
    localparam state_t S_RD_DATA  = 4'd3;
    localparam state_t S_RD_RPLY  = 4'd4;
    localparam state_t S_WR_WAIT  = 4'd5;
    localparam state_t S_WR_RPLY  = 4'd6;
    localparam state_t S_VEC_DATA = 4'd7;
    localparam state_t S_VEC_RPLY = 4'd8;

    localparam logic [15:0] A_RAM_TOP  = 16'o100000;
    localparam logic [15:0] A_TTY_BASE = 16'o177560;
    localparam logic [15:0] A_TTY_TOP  = 16'o177567;
    localparam logic [15:0] A_HCR      = 16'o177710;
    localparam logic [15:0] A_OUTHEX   = 16'o177714;
    localparam logic [15:0] A_SYS      = 16'o177716;
    localparam logic [15:0] A_REG_TOP  = 16'o177717;

    localparam logic [15:0] VEC_0 = 16'o000060;
    localparam logic [15:0] VEC_1 = 16'o000064;

    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/qbus_irq_arb.sv
// rtl/qbus_irq_arb.sv - fixed-priority interrupt encoder with vector mux (lowest index wins)
module qbus_irq_arb
    import qbus_pkg::*;
#(
    parameter int                 NIRQ = 2,
    parameter logic [16*NIRQ-1:0] VEC  = {VEC_1, VEC_0}
) (
    input  logic [NIRQ-1:0] irq_req,
    output logic [NIRQ-1:0] winner,
    output logic [15:0]     vector,
    output logic            any
);

    // Scan from the top down so the lowest set index overwrites last.
    always_comb begin
        winner = '0;
        vector = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq_req[i]) begin
                winner    = '0;
                winner[i] = 1'b1;
                vector    = VEC[16*i +: 16];
            end
        end
        any = |irq_req;
    end

endmodule

// File: rtl/qbus_slave_ctl.sv
// rtl/qbus_slave_ctl.sv - clocked QBUS slave: address decode, backend strobes, RPLY and IAKO vectors
module qbus_slave_ctl
    import qbus_pkg::*;
#(
    parameter logic [15:0]        RAM_TOP  = A_RAM_TOP,
    parameter logic [15:0]        REG_BASE = A_TTY_BASE,
    parameter logic [15:0]        REG_TOP  = A_REG_TOP,
    parameter int                 WAIT     = 0,
    parameter int                 NIRQ     = 2,
    parameter logic [16*NIRQ-1:0] VEC      = {VEC_1, VEC_0}
) (
    input  logic            clk,
    input  logic            dclo_n,
    input  logic [15:0]     ad_in_n,
    output logic [15:0]     ad_out_n,
    output logic            ad_oe,
    input  logic            sync_n,
    input  logic            din_n,
    input  logic            dout_n,
    input  logic            wtbt_n,
    input  logic            iako_n,
    output logic            rply_n,
    output logic            virq_n,
    output logic [15:0]     bus_addr,
    output logic [15:0]     bus_wdata,
    output logic            bus_byte,
    output logic            bus_ram,
    output logic            bus_rd,
    output logic            bus_wr,
    input  logic [15:0]     bus_rdata,
    input  logic            bus_ack,
    input  logic [NIRQ-1:0] irq_req,
    output logic [NIRQ-1:0] irq_ack
);

    state_t          state;
    logic            sync_q, din_q, dout_q;
    logic            sel, acked;
    logic [3:0]      cnt;
    logic [15:0]     rdata_q;
    logic [NIRQ-1:0] win_q;

    logic [NIRQ-1:0] arb_win;
    logic [15:0]     arb_vec;
    logic            arb_any;

    logic        sync_fall, din_fall, dout_fall;
    logic        ack_seen, ready, in_vec, abort;
    logic [15:0] addr_in;
    logic        addr_ram, addr_reg;

    qbus_irq_arb #(.NIRQ(NIRQ), .VEC(VEC)) u_arb (
        .irq_req (irq_req),
        .winner  (arb_win),
        .vector  (arb_vec),
        .any     (arb_any)
    );

    assign sync_fall = sync_q & ~sync_n;
    assign din_fall  = din_q & ~din_n;
    assign dout_fall = dout_q & ~dout_n;
    assign addr_in   = ~ad_in_n;
    assign addr_ram  = addr_in < RAM_TOP;
    assign addr_reg  = in_window(addr_in, REG_BASE, REG_TOP);

    // The ack may arrive together with the strobe, so the live input counts as seen.
    assign ack_seen  = acked | bus_ack;
    assign ready     = ack_seen && (cnt == 4'd0);
    assign in_vec    = (state == S_VEC_DATA) || (state == S_VEC_RPLY);
    assign abort     = sync_n && (state != S_IDLE) && !in_vec;

    always_ff @(posedge clk or negedge dclo_n) begin
        if (!dclo_n) begin
            state     <= S_IDLE;
            sync_q    <= 1'b1;
            din_q     <= 1'b1;
            dout_q    <= 1'b1;
            sel       <= 1'b0;
            acked     <= 1'b0;
            cnt       <= 4'd0;
            rdata_q   <= 16'h0000;
            win_q     <= '0;
            rply_n    <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out_n  <= 16'hFFFF;
            virq_n    <= 1'b1;
            bus_addr  <= 16'h0000;
            bus_wdata <= 16'h0000;
            bus_byte  <= 1'b0;
            bus_ram   <= 1'b0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            irq_ack   <= '0;
        end else begin
            sync_q  <= sync_n;
            din_q   <= din_n;
            dout_q  <= dout_n;
            bus_rd  <= 1'b0;
            bus_wr  <= 1'b0;
            irq_ack <= '0;
            // Held released while a vector is on the bus so one request cannot fire twice.
            virq_n  <= in_vec ? 1'b1 : ~arb_any;

            if (abort) begin
                rply_n   <= 1'b1;
                ad_oe    <= 1'b0;
                ad_out_n <= 16'hFFFF;
                state    <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (sync_fall) begin
                            bus_addr <= addr_in;
                            sel      <= addr_ram | addr_reg;
                            bus_ram  <= addr_ram;
                            state    <= S_ADDR;
                        end else if (!iako_n && !din_n && arb_any) begin
                            win_q    <= arb_win;
                            ad_out_n <= ~arb_vec;
                            ad_oe    <= 1'b1;
                            state    <= S_VEC_DATA;
                        end
                    end
                    S_ADDR: begin
                        // An unselected address never replies; the CPU times out.
                        if (sel) begin
                            if (din_fall) begin
                                bus_rd <= 1'b1;
                                acked  <= 1'b0;
                                cnt    <= 4'(WAIT);
                                state  <= S_RD_WAIT;
                            end else if (dout_fall) begin
                                bus_wdata <= addr_in;
                                bus_byte  <= ~wtbt_n;
                                bus_wr    <= 1'b1;
                                acked     <= 1'b0;
                                cnt       <= 4'(WAIT);
                                state     <= S_WR_WAIT;
                            end
                        end
                    end
                    S_RD_WAIT: begin
                        if (bus_ack && !acked) begin
                            acked   <= 1'b1;
                            rdata_q <= bus_rdata;
                        end
                        if (ready) begin
                            ad_out_n <= ~(acked ? rdata_q : bus_rdata);
                            ad_oe    <= 1'b1;
                            state    <= S_RD_DATA;
                        end else if (ack_seen) begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_RD_DATA: begin
                        rply_n <= 1'b0;
                        state  <= S_RD_RPLY;
                    end
                    S_RD_RPLY: begin
                        if (din_n) begin
                            rply_n   <= 1'b1;
                            ad_oe    <= 1'b0;
                            ad_out_n <= 16'hFFFF;
                            state    <= S_ADDR;
                        end
                    end
                    S_WR_WAIT: begin
                        if (bus_ack) acked <= 1'b1;
                        if (ready) begin
                            rply_n <= 1'b0;
                            state  <= S_WR_RPLY;
                        end else if (ack_seen) begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_WR_RPLY: begin
                        if (dout_n) begin
                            rply_n <= 1'b1;
                            state  <= S_ADDR;
                        end
                    end
                    S_VEC_DATA: begin
                        rply_n  <= 1'b0;
                        irq_ack <= win_q;
                        state   <= S_VEC_RPLY;
                    end
                    S_VEC_RPLY: begin
                        if (din_n) begin
                            rply_n   <= 1'b1;
                            ad_oe    <= 1'b0;
                            ad_out_n <= 16'hFFFF;
                            state    <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qbus_slave_ctl.sv
// tb/tb_qbus_slave_ctl.sv - scoreboard bench: CPU/backend stimulus with a decoupled event monitor
module tb_qbus_slave_ctl;

    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_RP = 2;
    localparam int K_IA = 3;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] d;
        logic        b;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic        clk = 1'b0;
    logic        dclo_n = 1'b0;
    logic [15:0] ad_in_n = 16'hFFFF;
    logic        sync0_n = 1'b1, sync1_n = 1'b1;
    logic        din_n = 1'b1, dout_n = 1'b1, wtbt_n = 1'b1, iako_n = 1'b1;
    logic [15:0] rdata = 16'h0000;
    logic [1:0]  irq_req = 2'b00;
    logic [1:0]  irq_none = 2'b00;
    logic        bus_ack;
    logic        tgt = 1'b0;
    int          ack_dly = 0;
    int          pend = 0;
    logic        ack_late = 1'b0;

    logic [15:0] ado0, ado1, addr0, addr1, wd0, wd1;
    logic        oe0, oe1, rply0_n, rply1_n, virq0_n, virq1_n;
    logic        byte0, byte1, ram0, ram1, rd0, rd1, wr0, wr1;
    logic [1:0]  iack0, iack1;

    qbus_slave_ctl #(.WAIT(0)) dut0 (
        .clk(clk), .dclo_n(dclo_n), .ad_in_n(ad_in_n), .ad_out_n(ado0), .ad_oe(oe0),
        .sync_n(sync0_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n), .iako_n(iako_n),
        .rply_n(rply0_n), .virq_n(virq0_n), .bus_addr(addr0), .bus_wdata(wd0),
        .bus_byte(byte0), .bus_ram(ram0), .bus_rd(rd0), .bus_wr(wr0),
        .bus_rdata(rdata), .bus_ack(bus_ack), .irq_req(irq_req), .irq_ack(iack0)
    );

    qbus_slave_ctl #(.WAIT(3)) dut1 (
        .clk(clk), .dclo_n(dclo_n), .ad_in_n(ad_in_n), .ad_out_n(ado1), .ad_oe(oe1),
        .sync_n(sync1_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n), .iako_n(iako_n),
        .rply_n(rply1_n), .virq_n(virq1_n), .bus_addr(addr1), .bus_wdata(wd1),
        .bus_byte(byte1), .bus_ram(ram1), .bus_rd(rd1), .bus_wr(wr1),
        .bus_rdata(rdata), .bus_ack(bus_ack), .irq_req(irq_none), .irq_ack(iack1)
    );

    wire [15:0] m_ad    = tgt ? ado1 : ado0;
    wire [15:0] m_addr  = tgt ? addr1 : addr0;
    wire [15:0] m_wdata = tgt ? wd1 : wd0;
    wire        m_oe    = tgt ? oe1 : oe0;
    wire        m_rply_n = tgt ? rply1_n : rply0_n;
    wire        m_virq_n = tgt ? virq1_n : virq0_n;
    wire        m_byte  = tgt ? byte1 : byte0;
    wire        m_ram   = tgt ? ram1 : ram0;
    wire        m_rd    = tgt ? rd1 : rd0;
    wire        m_wr    = tgt ? wr1 : wr0;
    wire [1:0]  m_iack  = tgt ? iack1 : iack0;

    assign bus_ack = ((m_rd | m_wr) && (ack_dly == 0)) || ack_late;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Backend model: acknowledge ack_dly cycles after the strobe cycle.
    always @(posedge clk) begin
        #2;
        ack_late = 1'b0;
        if (m_rd | m_wr) pend = ack_dly;
        else if (pend > 0) begin
            pend--;
            if (pend == 0) ack_late = 1'b1;
        end
    end

    task automatic push(input int kind, input logic [15:0] a, input logic [15:0] d,
                        input logic b, input int lat);
        exp_t e;
        e.kind = kind; e.a = a; e.d = d; e.b = b; e.lat = lat;
        q.push_back(e);
    endtask

    task automatic handle(input int kind, input logic [15:0] a, input logic [15:0] d,
                          input logic b, input int lat);
        exp_t e;
        logic bad;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event kind=%0d got a=%o d=%o b=%0d lat=%0d required no event",
                     kind, a, d, b, lat);
            return;
        end
        e = q.pop_front();
        bad = (e.kind != kind);
        case (kind)
            K_RD: bad = bad || (a != e.a);
            K_WR: bad = bad || (a != e.a) || (d != e.d) || (b != e.b);
            K_RP: bad = bad || (a[0] != e.a[0]) || (e.a[0] && (d != e.d)) ||
                        ((e.lat >= 0) && (lat != e.lat));
            default: bad = bad || (d != e.d);
        endcase
        if (bad) begin
            n_err++;
            $display("FAIL event_%0d: got kind=%0d a=%o d=%o b=%0d lat=%0d required kind=%0d a=%o d=%o b=%0d lat=%0d",
                     n_vec, kind, a, d, b, lat, e.kind, e.a, e.d, e.b, e.lat);
        end
    endtask

    logic prev_rply = 1'b1;
    logic prev_ack  = 1'b0;
    int   ack_cyc   = 0;

    always @(negedge clk) begin
        if (bus_ack && !prev_ack) ack_cyc = cyc;
        prev_ack = bus_ack;
        if (m_rd) handle(K_RD, m_addr, 16'h0000, 1'b0, 0);
        if (m_wr) handle(K_WR, m_addr, m_wdata, m_byte, 0);
        if (prev_rply && !m_rply_n) handle(K_RP, {15'b0, m_oe}, m_ad, 1'b0, cyc - ack_cyc);
        prev_rply = m_rply_n;
        if (m_iack != 2'b00) handle(K_IA, 16'h0000, {14'b0, m_iack}, 1'b0, 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rply(input string name);
        for (int k = 0; k < 60; k++) begin
            tick();
            if (m_rply_n == 1'b0) break;
        end
        check({name, "_rply_low"}, {31'b0, m_rply_n}, 32'd0);
    endtask

    task automatic cpu_addr(input logic [15:0] a);
        ad_in_n = ~a;
        if (tgt) sync1_n = 1'b0;
        else sync0_n = 1'b0;
        tick();
        ad_in_n = 16'hFFFF;
    endtask

    task automatic cpu_end();
        sync0_n = 1'b1;
        sync1_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic cpu_read(input string name);
        din_n = 1'b0;
        wait_rply(name);
        din_n = 1'b1;
        tick();
        check({name, "_release"}, {30'b0, m_rply_n, m_oe}, 32'h2);
    endtask

    task automatic cpu_write(input string name, input logic [15:0] data, input logic byt);
        ad_in_n = ~data;
        wtbt_n  = ~byt;
        dout_n  = 1'b0;
        wait_rply(name);
        dout_n  = 1'b1;
        ad_in_n = 16'hFFFF;
        wtbt_n  = 1'b1;
        tick();
        check({name, "_release"}, {31'b0, m_rply_n}, 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_rply_n", {31'b0, rply0_n}, 32'd1);
        check("rst_ad_oe", {31'b0, oe0}, 32'd0);
        check("rst_ad_out_n", {16'b0, ado0}, 32'h0000FFFF);
        check("rst_virq_n", {31'b0, virq0_n}, 32'd1);
        check("rst_bus_addr", {16'b0, addr0}, 32'd0);
        check("rst_bus_wdata", {16'b0, wd0}, 32'd0);
        check("rst_strobes", {28'b0, rd0, wr0, byte0, ram0}, 32'd0);
        check("rst_irq_ack", {30'b0, iack0}, 32'd0);
        dclo_n = 1'b1;
        tick();

        // Word read from RAM, ack together with the strobe
        rdata = 16'o123456;
        push(K_RD, 16'o001000, 16'h0, 1'b0, 0);
        push(K_RP, 16'd1, ~16'o123456, 1'b0, 2);
        cpu_addr(16'o001000);
        check("ram_decode", {31'b0, m_ram}, 32'd1);
        cpu_read("rd_001000");
        cpu_end();

        // Byte write to an odd address
        push(K_WR, 16'o002001, 16'o000377, 1'b1, 0);
        push(K_RP, 16'd0, 16'h0, 1'b0, 1);
        cpu_addr(16'o002001);
        cpu_write("wrb_002001", 16'o000377, 1'b1);
        cpu_end();

        // Read-modify-write inside one SYNC
        rdata = 16'o007070;
        push(K_RD, 16'o000100, 16'h0, 1'b0, 0);
        push(K_RP, 16'd1, ~16'o007070, 1'b0, 2);
        push(K_WR, 16'o000100, 16'o070707, 1'b0, 0);
        push(K_RP, 16'd0, 16'h0, 1'b0, 1);
        cpu_addr(16'o000100);
        cpu_read("rmw_rd");
        cpu_write("rmw_wr", 16'o070707, 1'b0);
        cpu_end();

        // Register window read
        rdata = 16'o000200;
        push(K_RD, 16'o177560, 16'h0, 1'b0, 0);
        push(K_RP, 16'd1, ~16'o000200, 1'b0, 2);
        cpu_addr(16'o177560);
        check("reg_decode", {31'b0, m_ram}, 32'd0);
        cpu_read("rd_177560");
        cpu_end();

        // Unselected address: no strobe, no reply
        cpu_addr(16'o160000);
        check("unsel_ram", {31'b0, m_ram}, 32'd0);
        din_n = 1'b0;
        repeat (8) tick();
        check("unsel_no_rply", {31'b0, m_rply_n}, 32'd1);
        din_n = 1'b1;
        cpu_end();

        // Interrupt vectors: lowest requester first, then the other
        irq_req = 2'b11;
        tick();
        tick();
        check("virq_asserted", {31'b0, m_virq_n}, 32'd0);
        push(K_RP, 16'd1, ~16'o000060, 1'b0, -1);
        push(K_IA, 16'h0, 16'd1, 1'b0, 0);
        iako_n = 1'b0;
        din_n  = 1'b0;
        wait_rply("iako1");
        check("virq_forced", {31'b0, m_virq_n}, 32'd1);
        irq_req = 2'b10;
        din_n  = 1'b1;
        iako_n = 1'b1;
        tick();
        check("iako1_release", {30'b0, m_rply_n, m_oe}, 32'h2);
        tick();
        check("virq_again", {31'b0, m_virq_n}, 32'd0);
        push(K_RP, 16'd1, ~16'o000064, 1'b0, -1);
        push(K_IA, 16'h0, 16'd2, 1'b0, 0);
        iako_n = 1'b0;
        din_n  = 1'b0;
        wait_rply("iako2");
        irq_req = 2'b00;
        din_n  = 1'b1;
        iako_n = 1'b1;
        tick();
        check("iako2_release", {30'b0, m_rply_n, m_oe}, 32'h2);
        tick();
        tick();
        check("virq_idle", {31'b0, m_virq_n}, 32'd1);

        // WAIT=3 instance with the ack two cycles late
        tgt = 1'b1;
        ack_dly = 2;
        rdata = 16'o055555;
        push(K_RD, 16'o000200, 16'h0, 1'b0, 0);
        push(K_RP, 16'd1, ~16'o055555, 1'b0, 5);
        cpu_addr(16'o000200);
        cpu_read("w3_rd");
        cpu_end();
        push(K_WR, 16'o000202, 16'o012345, 1'b0, 0);
        push(K_RP, 16'd0, 16'h0, 1'b0, 4);
        cpu_addr(16'o000202);
        cpu_write("w3_wr", 16'o012345, 1'b0);
        cpu_end();
        tick();
        tgt = 1'b0;

        // SYNC rises while waiting for a slow backend
        ack_dly = 6;
        push(K_RD, 16'o000400, 16'h0, 1'b0, 0);
        cpu_addr(16'o000400);
        din_n = 1'b0;
        tick();
        tick();
        sync0_n = 1'b1;
        din_n = 1'b1;
        tick();
        check("abort_sync", {30'b0, m_rply_n, m_oe}, 32'h2);
        repeat (10) tick();
        check("abort_late_ack", {31'b0, m_rply_n}, 32'd1);

        // Power-fail reset in the middle of a write
        push(K_WR, 16'o000500, 16'o111111, 1'b0, 0);
        cpu_addr(16'o000500);
        ad_in_n = ~16'o111111;
        dout_n = 1'b0;
        tick();
        tick();
        dclo_n = 1'b0;
        #2;
        check("dclo_abort", {30'b0, m_rply_n, m_oe}, 32'h2);
        check("dclo_addr", {16'b0, m_addr}, 32'd0);
        dclo_n = 1'b1;
        dout_n = 1'b1;
        ad_in_n = 16'hFFFF;
        sync0_n = 1'b1;
        repeat (10) tick();
        check("dclo_late_ack", {31'b0, m_rply_n}, 32'd1);

        // Normal traffic resumes after both aborts
        ack_dly = 0;
        rdata = 16'o000001;
        push(K_RD, 16'o000600, 16'h0, 1'b0, 0);
        push(K_RP, 16'd1, ~16'o000001, 1'b0, 2);
        cpu_addr(16'o000600);
        cpu_read("rd_recover");
        cpu_end();

        repeat (4) tick();
        check("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
